imul_rr_scheduler: RTL
======================

# imul_rr_scheduler

Round-robin scheduler that shares one iterative integer multiplier (IntMulBase-class unit, 64-bit operand stream in, 32-bit product stream out) between NREQ requesters. It sits between the requesters' val/rdy streams and the single multiplier instance. It keeps exactly one transaction in flight and routes each product back to the requester that issued it.

## Interface
- NREQ, 2, number of requesters (2..4)
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low; asserted (0) clears all state immediately
- req_val  in  NREQ  per-requester operand valid
- req_rdy  out  NREQ  per-requester operand ready
- req_msg  in  NREQ×64  per-requester operands, {a[63:32], b[31:0]}
- resp_val  out  NREQ  per-requester product valid
- resp_rdy  in  NREQ  per-requester product ready
- resp_msg  out  32  product, shared bus, meaningful only where resp_val set
- mul_istream_val/rdy/msg  out/in/out  1/1/64  to multiplier input stream
- mul_ostream_val/rdy/msg  in/out/in  1/1/32  from multiplier output stream
- grant_cnt  out  NREQ×32  accepted-transaction counters (only with IMUL_RR_SCHED_PERF_EN)

## Operation
- FSM: IDLE -> ISSUE -> WAIT -> IDLE.
- IDLE: winner = first requester with req_val set, searching from ptr upward modulo NREQ. req_rdy[winner]=1 combinationally, all others 0. On fire: latch req_msg[winner] into op_reg, winner into gnt_reg, go ISSUE. No req_val: stay.
- ISSUE: mul_istream_val=1, msg=op_reg. On mul_istream_rdy: go WAIT.
- WAIT: resp_val[gnt_reg]=mul_ostream_val; mul_ostream_rdy=resp_rdy[gnt_reg]; resp_msg=mul_ostream_msg. On fire: ptr<=gnt_reg+1 mod NREQ, go IDLE.
- Handshake fire = val & rdy in same cycle. Messages pass unmodified; no arithmetic on data.
- mul_ostream_rdy=0 outside WAIT; mul_istream_val=0 outside ISSUE; req_rdy all 0 outside IDLE.
- Backpressure: requester holding resp_rdy=0 stalls the scheduler in WAIT; other requesters wait.

## Timing
- Reset (reset=0): state IDLE, ptr 0, op_reg/gnt_reg 0, counters 0; all outputs 0 (req_rdy forced 0 while reset asserted).
- Reset mid-transaction: transaction dropped, no response delivered; multiplier shares reset.
- Minimum overhead: accept cycle N, issue at N+1, response visible combinationally the cycle multiplier asserts val; next accept earliest the cycle after response fire.
- Simultaneous req_val on all inputs: strict rotation; each requester granted once per NREQ grants.
- ptr wraps NREQ-1 -> 0.
- req_val dropping before fire: no grant, no state change.
- Response is never delivered to a requester other than gnt_reg.

## Configuration
- IMUL_RR_SCHED_PERF_EN defined: grant_cnt port present; grant_cnt[i] increments on each req fire of requester i, wraps 2^32-1 -> 0, clears on reset.
- Undefined: port and counters absent; behaviour otherwise identical.

## Structure
- Package imul_rr_sched_pkg: state enum (IDLE, ISSUE, WAIT), operand/product width constants (64, 32), NREQ max (4).
- Sub-module imul_rr_arb: combinational rotating-priority arbiter (req vector, ptr in; one-hot grant, index out). FSM, registers, routing, counters in top.
- display_trace task: state, gnt_reg, ptr, active stream fires.

## Test plan
- Single requester: req0 sends a=2,b=3 -> resp_val[0] with 6, resp_val[1] never set, ptr=1 afterward.
- Contention: both requesters hold val, req0 (4,5) req1 (10,13) -> grants 0,1,0,1; products 20 and 130 on correct ports.
- Response backpressure: resp_rdy[1]=0 for 5 cycles on (0xFFFFFFFF,0x12345678) -> mul_ostream_rdy held 0, req_rdy all 0, product 0xEDCBA988 delivered when rdy rises.
- Multiplier input stall: mul_istream_rdy=0 for 3 cycles -> msg held stable at op_reg, req_msg changes ignored.
- Reset mid-WAIT: reset=0 asynchronously -> all outputs 0 same cycle, state IDLE, ptr 0, next request from req1 granted normally.
- PERF_EN: 3 grants req0, 2 req1 -> grant_cnt = {2,3}; without macro bench compiles with no grant_cnt.

Source files
------------

// File: rtl/imul_rr_sched_pkg.sv
// Shared types and widths for the round-robin multiplier scheduler.
// The optional grant counters are enabled by defining IMUL_RR_SCHED_PERF_EN.
package imul_rr_sched_pkg;

   localparam int OP_W     = 64;
   localparam int PROD_W   = 32;
   localparam int NREQ_MAX = 4;
   localparam int CNT_W    = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } state_t;

endpackage

// File: rtl/imul_rr_arb.sv
// Combinational rotating-priority arbiter: the first set request at or after
// i_ptr, wrapping modulo NREQ, wins.
module imul_rr_arb
   import imul_rr_sched_pkg::*;
#(
   parameter  int NREQ  = 2,
   localparam int PTR_W = $clog2(NREQ)
) (
   input  logic [NREQ-1:0]  i_req,
   input  logic [PTR_W-1:0] i_ptr,
   output logic [NREQ-1:0]  o_gnt,
   output logic [PTR_W-1:0] o_idx,
   output logic             o_any
);

   logic [PTR_W-1:0] w_cand;

   // Walk the requesters in priority order and keep the first one found.
   always_comb begin
      o_gnt  = '0;
      o_idx  = '0;
      o_any  = 1'b0;
      w_cand = '0;
      for (int k = 0; k < NREQ; k++) begin
         w_cand = PTR_W'((int'(i_ptr) + k) % NREQ);
         if (!o_any && i_req[w_cand]) begin
            o_any         = 1'b1;
            o_idx         = w_cand;
            o_gnt[w_cand] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/imul_rr_scheduler.sv
// Shares one iterative multiplier among NREQ requesters, one transaction in
// flight at a time. Define IMUL_RR_SCHED_PERF_EN for per-requester grant counters.
module imul_rr_scheduler
   import imul_rr_sched_pkg::*;
#(
   parameter int NREQ = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NREQ-1:0]      req_val,
   output logic [NREQ-1:0]      req_rdy,
   input  logic [NREQ*OP_W-1:0] req_msg,
   output logic [NREQ-1:0]      resp_val,
   input  logic [NREQ-1:0]      resp_rdy,
   output logic [PROD_W-1:0]    resp_msg,
   output logic                 mul_istream_val,
   input  logic                 mul_istream_rdy,
   output logic [OP_W-1:0]      mul_istream_msg,
   input  logic                 mul_ostream_val,
   output logic                 mul_ostream_rdy,
   input  logic [PROD_W-1:0]    mul_ostream_msg
`ifdef IMUL_RR_SCHED_PERF_EN
   ,
   output logic [NREQ*CNT_W-1:0] grant_cnt
`endif
);

   localparam int PTR_W = $clog2(NREQ);

   state_t           r_state;
   state_t           w_nextState;
   logic [PTR_W-1:0] r_ptr;
   logic [PTR_W-1:0] r_gnt;
   logic [OP_W-1:0]  r_op;

   logic [NREQ-1:0]  w_arbGnt;
   logic [PTR_W-1:0] w_arbIdx;
   logic             w_arbAny;
   logic [OP_W-1:0]  w_reqOps [NREQ];
   logic [OP_W-1:0]  w_selMsg;
   logic             w_reqFire;
   logic             w_respFire;
   logic [PTR_W-1:0] w_ptrNext;

   imul_rr_arb #(.NREQ(NREQ)) u_arb (
      .i_req (req_val),
      .i_ptr (r_ptr),
      .o_gnt (w_arbGnt),
      .o_idx (w_arbIdx),
      .o_any (w_arbAny)
   );

   always_comb begin
      for (int i = 0; i < NREQ; i++) begin
         w_reqOps[i] = req_msg[i*OP_W +: OP_W];
      end
      w_selMsg = w_reqOps[w_arbIdx];
   end

   assign w_reqFire       = (r_state == IDLE) && w_arbAny;
   assign w_respFire      = (r_state == WAIT) && mul_ostream_val && resp_rdy[r_gnt];
   assign w_ptrNext       = (r_gnt == PTR_W'(NREQ - 1)) ? '0 : r_gnt + 1'b1;
   assign mul_istream_msg = r_op;

   // req_rdy is gated by reset so nothing can be accepted while it is held.
   always_comb begin
      w_nextState     = r_state;
      req_rdy         = '0;
      resp_val        = '0;
      resp_msg        = '0;
      mul_istream_val = 1'b0;
      mul_ostream_rdy = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (reset) begin
               req_rdy = w_arbGnt;
            end
            if (w_arbAny) begin
               w_nextState = ISSUE;
            end
         end
         ISSUE: begin
            mul_istream_val = 1'b1;
            if (mul_istream_rdy) begin
               w_nextState = WAIT;
            end
         end
         WAIT: begin
            resp_val[r_gnt] = mul_ostream_val;
            mul_ostream_rdy = resp_rdy[r_gnt];
            resp_msg        = mul_ostream_msg;
            if (mul_ostream_val && resp_rdy[r_gnt]) begin
               w_nextState = IDLE;
            end
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= IDLE;
         r_ptr   <= '0;
         r_gnt   <= '0;
         r_op    <= '0;
      end else begin
         r_state <= w_nextState;
         if (w_reqFire) begin
            r_gnt <= w_arbIdx;
            r_op  <= w_selMsg;
         end
         // Priority moves past the requester just served.
         if (w_respFire) begin
            r_ptr <= w_ptrNext;
         end
      end
   end

`ifdef IMUL_RR_SCHED_PERF_EN
   logic [CNT_W-1:0] r_grantCnt [NREQ];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NREQ; i++) begin
            r_grantCnt[i] <= '0;
         end
      end else if (w_reqFire) begin
         r_grantCnt[w_arbIdx] <= r_grantCnt[w_arbIdx] + 1'b1;
      end
   end

   always_comb begin
      for (int i = 0; i < NREQ; i++) begin
         grant_cnt[i*CNT_W +: CNT_W] = r_grantCnt[i];
      end
   end
`endif

endmodule
